// File: rtl/sad_result_reader_pkg.sv
// Shared types and constants for the SAD result reader: partition-type codes,
// per-type entry counts and SAD widths, snapshot payload structs, FSM states.
// Optional MV payload is enabled by defining SAD_MV_EN.
package sad_me_pkg;

    localparam int unsigned MV_W      = 6;
    localparam int unsigned TYPE_W    = 3;
    localparam int unsigned IDX_W     = 5;
    localparam int unsigned SAD_W     = 16;
    localparam int unsigned REC_COUNT = 100;

    localparam int unsigned N_4X8   = 32;
    localparam int unsigned N_8X4   = 32;
    localparam int unsigned N_8X8   = 16;
    localparam int unsigned N_8X16  = 8;
    localparam int unsigned N_16X8  = 8;
    localparam int unsigned N_16X16 = 4;

    localparam int unsigned W_4X8   = 13;
    localparam int unsigned W_8X4   = 13;
    localparam int unsigned W_8X8   = 14;
    localparam int unsigned W_8X16  = 15;
    localparam int unsigned W_16X8  = 15;
    localparam int unsigned W_16X16 = 16;

    typedef enum logic [TYPE_W-1:0] {
        PT_4X8   = 3'd0,
        PT_8X4   = 3'd1,
        PT_8X8   = 3'd2,
        PT_8X16  = 3'd3,
        PT_16X8  = 3'd4,
        PT_16X16 = 3'd5
    } part_type_e;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    // Packed 2-D fields share the flat bus layout: entry i at [i*W+W-1:i*W].
    typedef struct packed {
        logic [N_16X16-1:0][W_16X16-1:0] s16x16;
        logic [N_16X8-1:0][W_16X8-1:0]   s16x8;
        logic [N_8X16-1:0][W_8X16-1:0]   s8x16;
        logic [N_8X8-1:0][W_8X8-1:0]     s8x8;
        logic [N_8X4-1:0][W_8X4-1:0]     s8x4;
        logic [N_4X8-1:0][W_4X8-1:0]     s4x8;
    } sad_snap_t;

`ifdef SAD_MV_EN
    typedef struct packed {
        logic [N_16X16-1:0][2*MV_W-1:0] m16x16;
        logic [N_16X8-1:0][2*MV_W-1:0]  m16x8;
        logic [N_8X16-1:0][2*MV_W-1:0]  m8x16;
        logic [N_8X8-1:0][2*MV_W-1:0]   m8x8;
        logic [N_8X4-1:0][2*MV_W-1:0]   m8x4;
        logic [N_4X8-1:0][2*MV_W-1:0]   m4x8;
    } mv_snap_t;
`endif

    // Number of entries held for a partition type.
    function automatic int unsigned entry_count(part_type_e t);
        case (t)
            PT_4X8:   return N_4X8;
            PT_8X4:   return N_8X4;
            PT_8X8:   return N_8X8;
            PT_8X16:  return N_8X16;
            PT_16X8:  return N_16X8;
            PT_16X16: return N_16X16;
            default:  return 1;
        endcase
    endfunction

    // Index of the final entry of a partition type.
    function automatic logic [IDX_W-1:0] last_idx(part_type_e t);
        return IDX_W'(entry_count(t) - 1);
    endfunction

endpackage

// File: rtl/sad_result_reader_if.sv
// Record stream from the SAD result reader to mode decision (valid/ready).
// out_mv exists only when SAD_MV_EN is defined.
interface sad_result_reader_if;
    import sad_me_pkg::*;

    logic              out_valid;
    logic              out_ready;
    logic [TYPE_W-1:0] out_type;
    logic [IDX_W-1:0]  out_idx;
    logic [SAD_W-1:0]  out_sad;
    logic              out_last;
`ifdef SAD_MV_EN
    logic [2*MV_W-1:0] out_mv;
`endif

    modport master (
`ifdef SAD_MV_EN
        output out_mv,
`endif
        output out_valid, out_type, out_idx, out_sad, out_last,
        input  out_ready
    );

    modport slave (
`ifdef SAD_MV_EN
        input  out_mv,
`endif
        input  out_valid, out_type, out_idx, out_sad, out_last,
        output out_ready
    );

endinterface

// File: rtl/sad_part_mux.sv
// Combinational entry select: (snapshot, type, idx) -> zero-extended SAD
// (and {mvy,mvx} when SAD_MV_EN is defined).
module sad_part_mux
    import sad_me_pkg::*;
(
`ifdef SAD_MV_EN
    input  mv_snap_t          mv_snap,
    output logic [2*MV_W-1:0] mv_c,
`endif
    input  sad_snap_t         snap,
    input  part_type_e        ptype,
    input  logic [IDX_W-1:0]  idx,
    output logic [SAD_W-1:0]  sad_c
);

    // Pick the addressed field and widen it to 16 bits.
    always_comb begin
        sad_c = '0;
        case (ptype)
            PT_4X8:   sad_c = SAD_W'(snap.s4x8[idx]);
            PT_8X4:   sad_c = SAD_W'(snap.s8x4[idx]);
            PT_8X8:   sad_c = SAD_W'(snap.s8x8[idx[3:0]]);
            PT_8X16:  sad_c = SAD_W'(snap.s8x16[idx[2:0]]);
            PT_16X8:  sad_c = SAD_W'(snap.s16x8[idx[2:0]]);
            PT_16X16: sad_c = snap.s16x16[idx[1:0]];
            default:  sad_c = '0;
        endcase
    end

`ifdef SAD_MV_EN
    // Same selection for the motion vector payload.
    always_comb begin
        mv_c = '0;
        case (ptype)
            PT_4X8:   mv_c = mv_snap.m4x8[idx];
            PT_8X4:   mv_c = mv_snap.m8x4[idx];
            PT_8X8:   mv_c = mv_snap.m8x8[idx[3:0]];
            PT_8X16:  mv_c = mv_snap.m8x16[idx[2:0]];
            PT_16X8:  mv_c = mv_snap.m16x8[idx[2:0]];
            PT_16X16: mv_c = mv_snap.m16x16[idx[1:0]];
            default:  mv_c = '0;
        endcase
    end
`endif

endmodule

// File: rtl/sad_result_reader.sv
// Snapshots all 100 partition minimum SADs on start and streams them, one
// record per transfer, to mode decision. Define SAD_MV_EN to carry MVs too.
module sad_result_reader
    import sad_me_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [N_4X8*W_4X8-1:0]        sad4x8,
    input  logic [N_8X4*W_8X4-1:0]        sad8x4,
    input  logic [N_8X8*W_8X8-1:0]        sad8x8,
    input  logic [N_8X16*W_8X16-1:0]      sad8x16,
    input  logic [N_16X8*W_16X8-1:0]      sad16x8,
    input  logic [N_16X16*W_16X16-1:0]    sad16x16,
`ifdef SAD_MV_EN
    input  logic [N_4X8*2*MV_W-1:0]       mv4x8,
    input  logic [N_8X4*2*MV_W-1:0]       mv8x4,
    input  logic [N_8X8*2*MV_W-1:0]       mv8x8,
    input  logic [N_8X16*2*MV_W-1:0]      mv8x16,
    input  logic [N_16X8*2*MV_W-1:0]      mv16x8,
    input  logic [N_16X16*2*MV_W-1:0]     mv16x16,
`endif
    output logic                          busy,
    output logic                          done,
    sad_result_reader_if.master           rec
);

    state_e           state_q, state_d;
    part_type_e       type_q, type_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             snap_ld;
    logic             rec_ld;
    logic             xfer;

    sad_snap_t        live, snap_q, mux_src;
    logic [SAD_W-1:0] sad_q, mux_sad_c;

    assign live.s4x8   = sad4x8;
    assign live.s8x4   = sad8x4;
    assign live.s8x8   = sad8x8;
    assign live.s8x16  = sad8x16;
    assign live.s16x8  = sad16x8;
    assign live.s16x16 = sad16x16;

    // The first record is loaded on the capture edge itself, so it must come
    // straight from the inputs rather than the (not yet loaded) snapshot.
    assign mux_src = (state_q == IDLE) ? live : snap_q;
    assign xfer    = valid_q && rec.out_ready;

`ifdef SAD_MV_EN
    mv_snap_t          mv_live, mv_snap_q, mv_src;
    logic [2*MV_W-1:0] mv_q, mux_mv_c;

    assign mv_live.m4x8   = mv4x8;
    assign mv_live.m8x4   = mv8x4;
    assign mv_live.m8x8   = mv8x8;
    assign mv_live.m8x16  = mv8x16;
    assign mv_live.m16x8  = mv16x8;
    assign mv_live.m16x16 = mv16x16;
    assign mv_src = (state_q == IDLE) ? mv_live : mv_snap_q;
`endif

    sad_part_mux u_mux (
`ifdef SAD_MV_EN
        .mv_snap (mv_src),
        .mv_c    (mux_mv_c),
`endif
        .snap    (mux_src),
        .ptype   (type_d),
        .idx     (idx_d),
        .sad_c   (mux_sad_c)
    );

    // FSM and control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            type_q  <= PT_4X8;
            idx_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state, record-sequencing and load-enable logic.
    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        last_d  = last_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        snap_ld = 1'b0;
        rec_ld  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SEND;
                    type_d  = PT_4X8;
                    idx_d   = '0;
                    valid_d = 1'b1;
                    last_d  = 1'b0;
                    busy_d  = 1'b1;
                    snap_ld = 1'b1;
                    rec_ld  = 1'b1;
                end
            end
            SEND: begin
                if (xfer) begin
                    if (last_q) begin
                        state_d = IDLE;
                        type_d  = PT_4X8;
                        idx_d   = '0;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        if (idx_q == last_idx(type_q)) begin
                            idx_d  = '0;
                            type_d = part_type_e'(type_q + TYPE_W'(1));
                        end else begin
                            idx_d  = idx_q + IDX_W'(1);
                        end
                        last_d = (type_d == PT_16X16) && (idx_d == last_idx(PT_16X16));
                        rec_ld = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Snapshot and output payload registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_q <= '0;
            sad_q  <= '0;
        end else begin
            if (snap_ld) snap_q <= live;
            if (rec_ld)  sad_q  <= mux_sad_c;
        end
    end

`ifdef SAD_MV_EN
    // MV snapshot and output register, advanced in lockstep with the SAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mv_snap_q <= '0;
            mv_q      <= '0;
        end else begin
            if (snap_ld) mv_snap_q <= mv_live;
            if (rec_ld)  mv_q      <= mux_mv_c;
        end
    end

    assign rec.out_mv = mv_q;
`endif

    assign rec.out_valid = valid_q;
    assign rec.out_type  = type_q;
    assign rec.out_idx   = idx_q;
    assign rec.out_sad   = sad_q;
    assign rec.out_last  = last_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_sad_result_reader.sv
// Directed bench for sad_result_reader: reset idle, full drain, back-pressure
// hold, snapshot isolation with ignored start, mid-drain reset, and (with
// SAD_MV_EN) MV payload routing.
module tb_sad_result_reader;
    import sad_me_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic busy, done;

    logic [31:0][12:0] sad4x8;
    logic [31:0][12:0] sad8x4;
    logic [15:0][13:0] sad8x8;
    logic [7:0][14:0]  sad8x16;
    logic [7:0][14:0]  sad16x8;
    logic [3:0][15:0]  sad16x16;
`ifdef SAD_MV_EN
    logic [31:0][11:0] mv4x8;
    logic [31:0][11:0] mv8x4;
    logic [15:0][11:0] mv8x8;
    logic [7:0][11:0]  mv8x16;
    logic [7:0][11:0]  mv16x8;
    logic [3:0][11:0]  mv16x16;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    sad_result_reader_if rec();

    sad_result_reader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sad4x8   (sad4x8),
        .sad8x4   (sad8x4),
        .sad8x8   (sad8x8),
        .sad8x16  (sad8x16),
        .sad16x8  (sad16x8),
        .sad16x16 (sad16x16),
`ifdef SAD_MV_EN
        .mv4x8    (mv4x8),
        .mv8x4    (mv8x4),
        .mv8x8    (mv8x8),
        .mv8x16   (mv8x16),
        .mv16x8   (mv16x8),
        .mv16x16  (mv16x16),
`endif
        .busy     (busy),
        .done     (done),
        .rec      (rec)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Hand-chosen value of each entry; 8x4 #31 is 13-bit all-ones, 16x16 #3 is 16-bit all-ones.
    function automatic logic [15:0] exp_sad(input int t, input int i);
        case (t)
            0:       return 16'(i + 1);
            1:       return (i == 31) ? 16'h1FFF : 16'(i * 3);
            2:       return 16'h2000 + 16'(i);
            3:       return 16'h4000 + 16'(i);
            4:       return 16'h7FF0 + 16'(i);
            default: return (i == 3) ? 16'hFFFF : 16'(i * 256 + 17);
        endcase
    endfunction

`ifdef SAD_MV_EN
    // Only 8x8 entry 5 carries a nonzero MV: {mvy=-3, mvx=7}.
    function automatic logic [11:0] exp_mv(input int t, input int i);
        return (t == 2 && i == 5) ? {6'h3D, 6'h07} : 12'h000;
    endfunction
`endif

    task automatic load_pattern();
        for (int i = 0; i < 32; i++) begin
            sad4x8[5'(i)] = 13'(exp_sad(0, i));
            sad8x4[5'(i)] = 13'(exp_sad(1, i));
        end
        for (int i = 0; i < 16; i++) sad8x8[4'(i)] = 14'(exp_sad(2, i));
        for (int i = 0; i < 8; i++) begin
            sad8x16[3'(i)] = 15'(exp_sad(3, i));
            sad16x8[3'(i)] = 15'(exp_sad(4, i));
        end
        for (int i = 0; i < 4; i++) sad16x16[2'(i)] = exp_sad(5, i);
`ifdef SAD_MV_EN
        mv4x8 = '0; mv8x4 = '0; mv8x8 = '0; mv8x16 = '0; mv16x8 = '0; mv16x16 = '0;
        mv8x8[4'd5] = {6'h3D, 6'h07};
`endif
    endtask

    task automatic scramble();
        sad4x8 = ~sad4x8; sad8x4 = ~sad8x4; sad8x8 = ~sad8x8;
        sad8x16 = ~sad8x16; sad16x8 = ~sad16x8; sad16x16 = ~sad16x16;
`ifdef SAD_MV_EN
        mv4x8 = '1; mv8x4 = '1; mv8x8 = '1; mv8x16 = '1; mv16x8 = '1; mv16x16 = '1;
`endif
    endtask

    task automatic pulse_start();
        @(negedge clk);
        rec.out_ready = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Walk the record stream, checking every visible record against the model.
    task automatic drain(input int stall_at, input int mutate_at, input int abort_at);
        int cnt[6] = '{32, 32, 16, 8, 8, 4};
        int n = 0;
        int cyc = 0;
        int stalled = 0;
        int et = 0;
        int ei = 0;
        while (n < REC_COUNT && cyc < 400) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            check("valid", 32'(rec.out_valid), 32'd1);
            check("busy", 32'(busy), 32'd1);
            check("type", 32'(rec.out_type), 32'(et));
            check("idx", 32'(rec.out_idx), 32'(ei));
            check("sad", 32'(rec.out_sad), 32'(exp_sad(et, ei)));
            check("last", 32'(rec.out_last), 32'(n == 99));
`ifdef SAD_MV_EN
            check("mv", 32'(rec.out_mv), 32'(exp_mv(et, ei)));
`endif
            if (n == abort_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_valid", 32'(rec.out_valid), 32'd0);
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_done", 32'(done), 32'd0);
                check("rst_sad", 32'(rec.out_sad), 32'd0);
                check("rst_type_idx", {24'd0, rec.out_type, rec.out_idx}, 32'd0);
                check("rst_last", 32'(rec.out_last), 32'd0);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (n == mutate_at) begin
                scramble();
                start = 1'b1;
            end
            if (n == stall_at && stalled < 5) begin
                rec.out_ready = 1'b0;
                stalled++;
            end else begin
                rec.out_ready = 1'b1;
                n++;
                if (ei == cnt[et] - 1) begin
                    ei = 0;
                    et++;
                end else begin
                    ei++;
                end
            end
        end
        if (n != REC_COUNT) check("drain_count", 32'(n), 32'(REC_COUNT));
    endtask

    // Post-drain: one-cycle done, idle; optionally start again in the done cycle.
    task automatic finish_drain(input bit restart);
        @(negedge clk);
        check("end_valid", 32'(rec.out_valid), 32'd0);
        check("end_busy", 32'(busy), 32'd0);
        check("end_done", 32'(done), 32'd1);
        if (restart) begin
            start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end else begin
            @(negedge clk);
            check("done_pulse", 32'(done), 32'd0);
            check("idle_valid", 32'(rec.out_valid), 32'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        rec.out_ready = 1'b0;
        load_pattern();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset without start.
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("idle_valid", 32'(rec.out_valid), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_done", 32'(done), 32'd0);
        end
        check("idle_sad", 32'(rec.out_sad), 32'd0);

        // Full back-to-back drain, then restart in the done cycle.
        pulse_start();
        drain(-1, -1, -1);
        finish_drain(1'b1);

        // Back-pressure at record 40 (type1 idx8).
        drain(40, -1, -1);
        finish_drain(1'b0);

        // Inputs change and start pulses mid-drain; snapshot must win.
        pulse_start();
        drain(-1, 10, -1);
        finish_drain(1'b0);
        load_pattern();

        // Reset at record 57, then a clean restart.
        pulse_start();
        drain(-1, -1, 57);
        @(negedge clk);
        check("post_rst_valid", 32'(rec.out_valid), 32'd0);
        pulse_start();
        drain(-1, -1, -1);
        finish_drain(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
